// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: one-bit-per-cycle restoring divider with valid/ready handshakes; define DIV_SIGNED_EN for signed_op support
module restoring_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d, quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             src_ready_q, src_ready_d, dst_valid_q, dst_valid_d, dbz_q, dbz_d;
  logic [WIDTH:0]   shifted, t;
  logic [WIDTH-1:0] a_step, q_step, op_a, op_b, q_fin, r_fin, r_zero;
`ifdef DIV_SIGNED_EN
  logic             negq_q, negq_d, negr_q, negr_d;
`endif
  always_comb begin
    shifted = {a_q, q_q[WIDTH-1]};
    t       = shifted - {1'b0, m_q};
    a_step  = t[WIDTH] ? shifted[WIDTH-1:0] : t[WIDTH-1:0];
    q_step  = {q_q[WIDTH-2:0], ~t[WIDTH]};
`ifdef DIV_SIGNED_EN
    // operate on magnitudes; the saved signs drive the fix-up at the result load
    op_a   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    op_b   = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
    q_fin  = negq_q ? -q_step : q_step;
    r_fin  = negr_q ? -a_step : a_step;
    r_zero = negr_q ? -q_q : q_q;
    negq_d = negq_q;
    negr_d = negr_q;
`else
    op_a   = dividend;
    op_b   = divisor;
    q_fin  = q_step;
    r_fin  = a_step;
    r_zero = q_q;
`endif
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (src_valid && src_ready_q) begin
        a_d     = '0;
        q_d     = op_a;
        m_d     = op_b;
        cnt_d   = '0;
        state_d = CALC;
`ifdef DIV_SIGNED_EN
        negq_d  = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        negr_d  = signed_op && dividend[WIDTH-1];
`endif
      end
      CALC: if (m_q == '0) begin
        quo_d   = '1;
        rem_d   = r_zero;
        dbz_d   = 1'b1;
        state_d = DONE;
      end else begin
        a_d   = a_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = q_fin;
          rem_d   = r_fin;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: if (dst_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    src_ready_d = state_d == IDLE;
    dst_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      src_ready_q <= 1'b0;
      dst_valid_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      src_ready_q <= src_ready_d;
      dst_valid_q <= dst_valid_d;
`ifdef DIV_SIGNED_EN
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end
  assign src_ready   = src_ready_q;
  assign dst_valid   = dst_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
